// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer: assembles an en-qualified bit stream into
// WIDTH-bit words held in a one-entry valid/ready output buffer.
module serial_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data,
  input  logic                     en,
  input  logic                     clear,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {EMPTY, FULL} buf_state_t;

  buf_state_t       state, state_nxt;
  logic [WIDTH-1:0] sr, shifted;
  logic             complete, load, drop;

  always_comb begin
    if (MSB_FIRST) shifted = {sr[WIDTH-2:0], data};
    else           shifted = {data, sr[WIDTH-1:1]};
  end

  // clear suppresses capture, so a word can never complete on a clear edge.
  assign complete  = en & ~clear & (bit_cnt == LAST);
  assign out_valid = (state == FULL);

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (complete) load = 1'b1;
          else          state_nxt = EMPTY;
        end else if (complete) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      sr      <= shifted;
      bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (load)       out_data <= shifted;
      if (clear)      overflow <= 1'b0;
      else if (drop)  overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_deser.sv
// Scoreboard bench for serial_deser: MSB-first and LSB-first instances share
// stimulus; monitors pop expected words whenever a new word is presented.
module tb_serial_deser;

  logic       clk = 1'b0;
  logic       reset, data, en, clear, out_ready;
  logic [7:0] out_data_m, out_data_l;
  logic       out_valid_m, out_valid_l, overflow_m, overflow_l;
  logic [2:0] bit_cnt_m, bit_cnt_l;

  int tests  = 0;
  int failed = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  logic       pv_m, pa_m, pv_l, pa_l;

  always #5 clk = ~clk;

  serial_deser #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .data(data), .en(en), .clear(clear),
    .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .overflow(overflow_m), .bit_cnt(bit_cnt_m)
  );

  serial_deser #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .data(data), .en(en), .clear(clear),
    .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .overflow(overflow_l), .bit_cnt(bit_cnt_l)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // A new word is on the output when valid rises or stays high after an accept.
  always @(negedge clk) begin
    if (reset) begin
      pv_m <= 1'b0; pa_m <= 1'b0;
    end else begin
      if (out_valid_m && (!pv_m || pa_m)) begin
        if (q_m.size() == 0) check("sb_m_unexpected", int'(out_data_m), -1);
        else                 check("sb_m_word", int'(out_data_m), int'(q_m.pop_front()));
      end
      pv_m <= out_valid_m;
      pa_m <= out_valid_m & out_ready;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      pv_l <= 1'b0; pa_l <= 1'b0;
    end else begin
      if (out_valid_l && (!pv_l || pa_l)) begin
        if (q_l.size() == 0) check("sb_l_unexpected", int'(out_data_l), -1);
        else                 check("sb_l_word", int'(out_data_l), int'(q_l.pop_front()));
      end
      pv_l <= out_valid_l;
      pa_l <= out_valid_l & out_ready;
    end
  end

  task automatic step(input logic e, input logic d);
    en   = e;
    data = d;
    @(posedge clk);
    #1;
  endtask

  // Bits go out w[7] first; the LSB-first instance therefore sees rev8(w).
  task automatic send_word(input logic [7:0] w, input bit expect_it);
    if (expect_it) begin
      q_m.push_back(w);
      q_l.push_back(rev8(w));
    end
    for (int i = 7; i >= 0; i--) step(1'b1, w[i]);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step(1'b0, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bits;
    reset = 1'b1; data = 1'b0; en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    #2;
    check("rst_data",  int'(out_data_m),  0);
    check("rst_valid", int'(out_valid_m), 0);
    check("rst_ovf",   int'(overflow_m),  0);
    check("rst_cnt",   int'(bit_cnt_m),   0);
    #10 reset = 1'b0;

    // Basic word, continuous enable.
    send_word(8'hA6, 1'b1);
    check("t1_data",  int'(out_data_m),  8'hA6);
    check("t1_valid", int'(out_valid_m), 1);
    check("t1_cnt",   int'(bit_cnt_m),   0);
    check("t1_data_lsb", int'(out_data_l), 8'h65);
    drain();
    check("t1_drained", int'(out_valid_m), 0);

    // Same bits with a gap cycle after each one.
    bits = 8'hA6;
    q_m.push_back(8'hA6);
    q_l.push_back(8'h65);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, bits[7-i]);
      check("t2_cnt_en", int'(bit_cnt_l), (i + 1) % 8);
      step(1'b0, 1'b1);
      check("t2_cnt_gap", int'(bit_cnt_l), (i + 1) % 8);
    end
    check("t2_data_lsb", int'(out_data_l), 8'h65);
    drain();

    // Back-to-back words; acceptance coincides with the next completion.
    send_word(8'h3C, 1'b1);
    q_m.push_back(8'hF0);
    q_l.push_back(rev8(8'hF0));
    bits = 8'hF0;
    for (int i = 7; i >= 1; i--) step(1'b1, bits[i]);
    check("t3_hold_data", int'(out_data_m), 8'h3C);
    out_ready = 1'b1;
    step(1'b1, bits[0]);
    out_ready = 1'b0;
    check("t3_valid", int'(out_valid_m), 1);
    check("t3_data",  int'(out_data_m),  8'hF0);
    check("t3_ovf",   int'(overflow_m),  0);
    drain();
    check("t3_drained", int'(out_valid_m), 0);

    // Overflow: second word dropped while the first waits.
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b0);
    check("t4_data", int'(out_data_m), 8'h11);
    check("t4_ovf",  int'(overflow_m), 1);
    drain();
    check("t4_valid_after", int'(out_valid_m), 0);
    check("t4_ovf_sticky",  int'(overflow_m),  1);
    clear = 1'b1;
    step(1'b0, 1'b0);
    clear = 1'b0;
    check("t4_ovf_clr", int'(overflow_m), 0);

    // Clear discards a partial word and the bit presented with it.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    check("t5_cnt5", int'(bit_cnt_m), 5);
    clear = 1'b1;
    step(1'b1, 1'b1);
    clear = 1'b0;
    check("t5_cnt_clr", int'(bit_cnt_m), 0);
    send_word(8'h81, 1'b1);
    check("t5_data", int'(out_data_m), 8'h81);
    drain();

    // Asynchronous reset mid-cycle with a word buffered and a partial word.
    send_word(8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    check("t6_pre_valid", int'(out_valid_m), 1);
    check("t6_pre_cnt",   int'(bit_cnt_m),   3);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", int'(out_valid_m), 0);
    check("t6_rst_data",  int'(out_data_m),  0);
    check("t6_rst_cnt",   int'(bit_cnt_m),   0);
    check("t6_rst_ovf",   int'(overflow_m),  0);
    @(negedge clk);
    #2 reset = 1'b0;
    send_word(8'h5A, 1'b1);
    check("t6_data", int'(out_data_m), 8'h5A);
    drain();

    step(1'b0, 1'b0);
    check("sb_drained", q_m.size() + q_l.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
